// File: rtl/lector_ventana_memoria.sv
// Fetches 3-pixel columns over an arbitrated memory bus and delivers every interior 3x3 window
// of the frame, in raster order, through a valid/ready handshake.
module lector_ventana_memoria #(
  parameter int ANCHO_DATO = 8,
  parameter int ANCHO_DIR  = 16,
  parameter int COLUMNAS   = 64,
  parameter int FILAS      = 48
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inicio,
  output logic                    solicitud_bus,
  input  logic                    bus_concedido,
  output logic                    mem_leer,
  output logic [ANCHO_DIR-1:0]    mem_dir,
  input  logic [ANCHO_DATO-1:0]   mem_dato,
  output logic [9*ANCHO_DATO-1:0] ventana,
  output logic                    ventana_valida,
  input  logic                    ventana_listo,
  output logic                    ocupado,
  output logic                    fin_cuadro
);

  localparam int ANCHO_C = $clog2(COLUMNAS);
  localparam int ANCHO_F = $clog2(FILAS);
  localparam logic [ANCHO_C-1:0]   ULTIMA_COL  = ANCHO_C'(COLUMNAS - 1);
  localparam logic [ANCHO_F-1:0]   ULTIMA_FILA = ANCHO_F'(FILAS - 2);
  localparam logic [ANCHO_DIR-1:0] DESPL_1     = ANCHO_DIR'(COLUMNAS);
  localparam logic [ANCHO_DIR-1:0] DESPL_2     = ANCHO_DIR'(2 * COLUMNAS);

  typedef enum logic [2:0] {
    REPOSO,
    SOLICITAR,
    LEER,
    CAPTURA,
    ENTREGAR,
    AVANZAR
  } estado_t;

  estado_t                  estado, estado_sig;
  logic [ANCHO_F-1:0]       fila;
  logic [ANCHO_C-1:0]       columna;
  logic [ANCHO_DIR-1:0]     base_fila;
  logic [1:0]               paso;
  logic [ANCHO_DATO-1:0]    col_sup, col_med;
  logic [9*ANCHO_DATO-1:0]  ventana_r, ventana_sig;
  logic [ANCHO_DIR-1:0]     despl;
  logic                     ultima_col, ultima_fila;

  assign ultima_col  = (columna == ULTIMA_COL);
  assign ultima_fila = (fila == ULTIMA_FILA);
  assign ventana     = ventana_r;

  always_comb begin
    case (paso)
      2'd0:    despl = '0;
      2'd1:    despl = DESPL_1;
      default: despl = DESPL_2;
    endcase
  end

  // Columns slide left; the freshly read column (top, middle, bottom) enters at j=2.
  always_comb begin
    ventana_sig = ventana_r;
    for (int i = 0; i < 3; i++) begin
      ventana_sig[(3*i)*ANCHO_DATO +: ANCHO_DATO]   = ventana_r[(3*i+1)*ANCHO_DATO +: ANCHO_DATO];
      ventana_sig[(3*i+1)*ANCHO_DATO +: ANCHO_DATO] = ventana_r[(3*i+2)*ANCHO_DATO +: ANCHO_DATO];
    end
    ventana_sig[2*ANCHO_DATO +: ANCHO_DATO] = col_sup;
    ventana_sig[5*ANCHO_DATO +: ANCHO_DATO] = col_med;
    ventana_sig[8*ANCHO_DATO +: ANCHO_DATO] = mem_dato;
  end

  always_comb begin
    estado_sig     = estado;
    solicitud_bus  = 1'b0;
    mem_leer       = 1'b0;
    mem_dir        = '0;
    ventana_valida = 1'b0;
    fin_cuadro     = 1'b0;
    case (estado)
      REPOSO: begin
        if (inicio) estado_sig = SOLICITAR;
      end
      SOLICITAR: begin
        solicitud_bus = 1'b1;
        if (bus_concedido) estado_sig = LEER;
      end
      LEER: begin
        mem_leer = 1'b1;
        mem_dir  = base_fila + ANCHO_DIR'(columna) + despl;
        if (paso == 2'd2) estado_sig = CAPTURA;
      end
      CAPTURA: begin
        // Only once three columns of the current row are loaded is the window meaningful.
        estado_sig = (columna >= ANCHO_C'(2)) ? ENTREGAR : AVANZAR;
      end
      ENTREGAR: begin
        ventana_valida = 1'b1;
        if (ventana_listo) estado_sig = AVANZAR;
      end
      AVANZAR: begin
        if (ultima_col && ultima_fila) begin
          fin_cuadro = 1'b1;
          estado_sig = REPOSO;
        end else begin
          estado_sig = SOLICITAR;
        end
      end
      default: estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado    <= REPOSO;
      fila      <= '0;
      columna   <= '0;
      base_fila <= '0;
      paso      <= '0;
      col_sup   <= '0;
      col_med   <= '0;
      ventana_r <= '0;
      ocupado   <= 1'b0;
    end else begin
      estado <= estado_sig;
      case (estado)
        REPOSO: begin
          if (inicio) begin
            fila      <= ANCHO_F'(1);
            columna   <= '0;
            base_fila <= '0;
            ocupado   <= 1'b1;
          end
        end
        SOLICITAR: paso <= '0;
        LEER: begin
          // Read data trails the strobe by one cycle.
          paso <= paso + 2'd1;
          if (paso == 2'd1) col_sup <= mem_dato;
          if (paso == 2'd2) col_med <= mem_dato;
        end
        CAPTURA: ventana_r <= ventana_sig;
        AVANZAR: begin
          if (!ultima_col) begin
            columna <= columna + ANCHO_C'(1);
          end else if (!ultima_fila) begin
            fila      <= fila + ANCHO_F'(1);
            columna   <= '0;
            base_fila <= base_fila + DESPL_1;
          end else begin
            ocupado <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
